store_lane_unit: RTL and testbench
==================================

# store_lane_unit

Parametrised store-path write-enable generator sitting between the EX/MEM pipeline register and the memory blocks (dmem, imem, I/O). It decodes the address tag to one or more target regions, aligns data and byte-lane masks to the access offset, and registers the result toward the memories. Misaligned stores may be split into two aligned word beats via a small FSM with a ready handshake back to the pipeline.

## Interface
Parameters:
- XLEN, 32, datapath width; 32 or 64. NBYTES = XLEN/8, LOG2B = log2(NBYTES).
- NUM_REGIONS, 2, number of memory regions; 1..ADDR_TAG_W.
- ADDR_TAG_W, 4, width of address tag addr[XLEN-1:XLEN-ADDR_TAG_W].
- WADDR_W, XLEN-ADDR_TAG_W-LOG2B, word address width (derived).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept; high iff FSM in S_IDLE.
- req_addr  in  XLEN  byte address.
- req_data  in  XLEN  store data, LSB-justified.
- req_size  in  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
- wr_valid  out  1  write beat valid.
- wr_addr  out  WADDR_W  word address (tag stripped).
- wr_data  out  XLEN  lane-aligned data.
- wr_mask  out  NUM_REGIONS*NBYTES  per-region byte enables; region r at [r*NBYTES +: NBYTES].
- err  out  1  one-cycle pulse on rejected request.

## Operation
- Accept: req_valid && req_ready on a rising edge.
- Region select: region r selected iff tag bit r = 1; several bits set = broadcast to all selected regions; tag bits >= NUM_REGIONS ignored.
- Alignment: off = addr[LOG2B-1:0]; base = (1<<(1<<size))-1; m2 = base<<off over 2*NBYTES; d2 = data<<(8*off) over 2*XLEN. Low half = beat 0, high half = beat 1.
- Beat 0: wr_addr = addr[XLEN-ADDR_TAG_W-1:LOG2B], wr_data = d2 low, selected region masks = m2 low, others 0.
- Split needed when m2 high half nonzero. Beat 1: wr_addr+1 (wraps mod 2^WADDR_W, tag preserved from request), d2 high, m2 high.
- No region selected: request accepted, no beat issued (wr_valid stays 0), no err.
- Illegal size (11 with XLEN=32): accepted, err=1, wr_valid=0, masks 0.
- FSM: S_IDLE -> (accept && split) -> S_SPLIT; S_SPLIT -> S_IDLE unconditionally next cycle. Otherwise S_IDLE holds.
- No downstream backpressure; memories accept every beat.

## Timing
- Outputs registered; beat 0 appears cycle after accept (latency 1). Beat 1 the cycle after beat 0.
- req_ready low exactly during S_SPLIT (one cycle per split store); back-to-back aligned stores at full throughput.
- wr_valid, err single-cycle unless another accept follows.
- Reset (rst_n=0 at edge): state S_IDLE, wr_valid 0, wr_addr 0, wr_data 0, wr_mask 0, err 0; req_ready 1 from combinational state; requests during reset ignored.
- Reset in S_SPLIT: beat 1 discarded, no partial write after reset.

## Configuration
- STORE_SPLIT_EN defined: misaligned stores split as above.
- Undefined: any request needing a split is rejected: err=1, wr_valid=0, masks 0; S_SPLIT unreachable, req_ready tied 1.

## Structure
- Package store_lane_pkg: size encodings (SZ_B, SZ_H, SZ_W, SZ_D), FSM state type (S_IDLE, S_SPLIT), region index constants (REG_DMEM=0, REG_IMEM=1).
- Sub-module store_align: combinational offset/size -> m2, d2 shifter, split flag, illegal flag; parent holds FSM, beat-1 holding register, output registers.

## Test plan (XLEN=32, NUM_REGIONS=2)
- sw addr 0x1000_0004 data 0x1234_5678 -> next cycle wr_valid=1, wr_addr=0x000_0001, wr_mask=8'b0000_1111, wr_data=0x1234_5678.
- sb addr 0x2000_0003 data 0x0000_00AB -> wr_mask=8'b1000_0000, wr_data=0xAB00_0000.
- sh addr 0x3000_0002 data 0xBEEF -> wr_mask=8'b1100_1100, wr_data=0xBEEF_0000 (broadcast).
- sw addr 0x1000_0006 data 0xDDCC_BBAA, STORE_SPLIT_EN -> beat0 wr_addr=1, mask 0000_1100, data 0xBBAA_0000; req_ready=0 one cycle; beat1 wr_addr=2, mask 0000_0011, data 0x0000_DDCC. Without macro -> err=1, no write.
- req_size=11 or tag 0x0 -> no write; err=1 only for size 11.
- rst_n=0 during S_SPLIT -> beat 1 never issued, all outputs 0, req_ready=1 next cycle.

Source files
------------

// File: rtl/store_lane_pkg.sv
// Shared encodings for the store lane unit: access sizes, FSM states and region indices.
package store_lane_pkg;

    // funct3[1:0] store size encodings
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Region index of each memory block in the tag / mask layout
    localparam int unsigned REG_DMEM = 0;
    localparam int unsigned REG_IMEM = 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_e;

endpackage

// File: rtl/store_align.sv
// Combinational lane aligner: turns byte offset and size into a two-word byte mask and
// shifted data, and flags accesses that spill into a second word or use an illegal size.
module store_align
    import store_lane_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned NBYTES = XLEN / 8,
    localparam int unsigned LOG2B  = $clog2(NBYTES),
    localparam int unsigned MW     = 2 * NBYTES
) (
    input  logic [LOG2B-1:0]  off,
    input  logic [1:0]        size,
    input  logic [XLEN-1:0]   data,
    output logic [MW-1:0]     m2,
    output logic [2*XLEN-1:0] d2,
    output logic              split,
    output logic              illegal
);

    logic [MW-1:0] base;

    // Size decode, lane shift and split detection
    always_comb begin
        base    = '0;
        illegal = (size == SZ_D) && (XLEN == 32);
        case (size)
            SZ_B:    base = MW'(1);
            SZ_H:    base = MW'(3);
            SZ_W:    base = MW'(15);
            default: base = MW'(255);
        endcase
        m2    = illegal ? '0 : (base << off);
        d2    = {{XLEN{1'b0}}, data} << {off, 3'b000};
        split = |m2[MW-1:NBYTES];
    end

endmodule

// File: rtl/store_lane_unit.sv
// Store-path write-enable generator: decodes the address tag to target regions, aligns
// data and byte masks, and registers one (or, for misaligned stores, two) write beats.
// Optional feature macro: STORE_SPLIT_EN enables splitting of word-crossing stores;
// without it such stores are rejected with err.
module store_lane_unit
    import store_lane_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_REGIONS = 2,
    parameter int unsigned ADDR_TAG_W  = 4,
    localparam int unsigned NBYTES     = XLEN / 8,
    localparam int unsigned LOG2B      = $clog2(NBYTES),
    localparam int unsigned WADDR_W    = XLEN - ADDR_TAG_W - LOG2B
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [XLEN-1:0]               req_addr,
    input  logic [XLEN-1:0]               req_data,
    input  logic [1:0]                    req_size,
    output logic                          wr_valid,
    output logic [WADDR_W-1:0]            wr_addr,
    output logic [XLEN-1:0]               wr_data,
    output logic [NUM_REGIONS*NBYTES-1:0] wr_mask,
    output logic                          err
);

`ifdef STORE_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    localparam int unsigned MW = NUM_REGIONS * NBYTES;

    state_e                  state_q, state_d;
    logic                    wr_valid_q, wr_valid_d;
    logic [WADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]         wr_data_q, wr_data_d;
    logic [MW-1:0]           wr_mask_q, wr_mask_d;
    logic                    err_q, err_d;
    // Beat-1 holding register for split stores
    logic [WADDR_W-1:0]      hold_addr_q, hold_addr_d;
    logic [XLEN-1:0]         hold_data_q, hold_data_d;
    logic [NBYTES-1:0]       hold_mask_q, hold_mask_d;
    logic [NUM_REGIONS-1:0]  hold_sel_q, hold_sel_d;

    logic [ADDR_TAG_W-1:0]   tag;
    logic [NUM_REGIONS-1:0]  sel;
    logic [WADDR_W-1:0]      waddr;
    logic [2*NBYTES-1:0]     m2;
    logic [2*XLEN-1:0]       d2;
    logic                    split, illegal, accept, reject, split_go;
    logic                    unused_tag;

    assign tag        = req_addr[XLEN-1 -: ADDR_TAG_W];
    assign sel        = tag[NUM_REGIONS-1:0];
    assign unused_tag = ^tag;
    assign waddr      = req_addr[XLEN-ADDR_TAG_W-1:LOG2B];

    store_align #(
        .XLEN (XLEN)
    ) u_align (
        .off     (req_addr[LOG2B-1:0]),
        .size    (req_size),
        .data    (req_data),
        .m2      (m2),
        .d2      (d2),
        .split   (split),
        .illegal (illegal)
    );

`ifdef STORE_SPLIT_EN
    assign req_ready = (state_q == S_IDLE);
`else
    assign req_ready = 1'b1;
`endif

    assign accept   = req_valid && req_ready;
    assign reject   = illegal || (split && !SplitEn);
    assign split_go = split && SplitEn;

    // Replicate a per-word byte mask into every selected region slot
    function automatic logic [MW-1:0] expand_mask(input logic [NUM_REGIONS-1:0] s,
                                                  input logic [NBYTES-1:0]      m);
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (s[i]) r[i*NBYTES +: NBYTES] = m;
        end
        return r;
    endfunction

    // Next-state and beat generation
    always_comb begin
        state_d     = state_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_mask_d   = '0;
        err_d       = 1'b0;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_mask_d = hold_mask_q;
        hold_sel_d  = hold_sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        if (|sel) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = waddr;
                            wr_data_d  = d2[XLEN-1:0];
                            wr_mask_d  = expand_mask(sel, m2[NBYTES-1:0]);
                        end
                        if (split_go) begin
                            state_d     = S_SPLIT;
                            hold_addr_d = waddr + 1'b1;  // wraps within the tag's space
                            hold_data_d = d2[2*XLEN-1:XLEN];
                            hold_mask_d = m2[2*NBYTES-1:NBYTES];
                            hold_sel_d  = sel;
                        end
                    end
                end
            end
            S_SPLIT: begin
                state_d    = S_IDLE;
                wr_valid_d = |hold_sel_q;
                wr_addr_d  = hold_addr_q;
                wr_data_d  = hold_data_q;
                wr_mask_d  = expand_mask(hold_sel_q, hold_mask_q);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, output and holding registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_mask_q   <= '0;
            err_q       <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_mask_q <= '0;
            hold_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_mask_q   <= wr_mask_d;
            err_q       <= err_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_mask_q <= hold_mask_d;
            hold_sel_q  <= hold_sel_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_mask  = wr_mask_q;
    assign err      = err_q;

endmodule

// File: tb/tb_store_lane_unit.sv
// Scoreboard bench for store_lane_unit (XLEN=32, NUM_REGIONS=2). Expectations are queued
// when a request is driven; a negedge monitor pops one per presented beat or error pulse.
module tb_store_lane_unit;

`ifdef STORE_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        wr_valid;
    logic [25:0] wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  wr_mask;
    logic        err;

    typedef struct {
        bit          is_err;
        logic [25:0] addr;
        logic [31:0] data;
        logic [7:0]  mask;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    store_lane_unit #(
        .XLEN        (32),
        .NUM_REGIONS (2),
        .ADDR_TAG_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [25:0] a, input logic [31:0] d, input logic [7:0] m);
        exp_t e;
        e.is_err = 1'b0;
        e.addr   = a;
        e.data   = d;
        e.mask   = m;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.addr   = '0;
        e.data   = '0;
        e.mask   = '0;
        q.push_back(e);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Monitor: every presented beat or error pulse must match the oldest expectation
    always @(negedge clk) begin
        if (wr_valid === 1'b1 || err === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_output", {62'd0, wr_valid, err}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("kind", {62'd0, wr_valid, err}, e.is_err ? 64'd1 : 64'd2);
                check("mask", {56'd0, wr_mask}, {56'd0, e.mask});
                if (!e.is_err) begin
                    check("addr", {38'd0, wr_addr}, {38'd0, e.addr});
                    check("data", {32'd0, wr_data}, {32'd0, e.data});
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b1;  // requests during reset must be ignored
        req_addr  = 32'h1000_0004;
        req_data  = 32'hFFFF_FFFF;
        req_size  = 2'b10;
        repeat (3) @(negedge clk);
        check("rst_valid", {63'd0, wr_valid}, 64'd0);
        check("rst_addr", {38'd0, wr_addr}, 64'd0);
        check("rst_data", {32'd0, wr_data}, 64'd0);
        check("rst_mask", {56'd0, wr_mask}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        idle();

        // Back-to-back aligned stores
        send(32'h1000_0004, 32'h1234_5678, 2'b10);
        push_beat(26'h000_0001, 32'h1234_5678, 8'b0000_1111);
        send(32'h2000_0003, 32'h0000_00AB, 2'b00);
        push_beat(26'h000_0000, 32'hAB00_0000, 8'b1000_0000);
        send(32'h3000_0002, 32'h0000_BEEF, 2'b01);
        push_beat(26'h000_0000, 32'hBEEF_0000, 8'b1100_1100);
        send(32'h1000_0001, 32'h0000_005A, 2'b00);
        push_beat(26'h000_0000, 32'h0000_5A00, 8'b0000_0010);
        // Illegal size, then no region selected
        send(32'h1000_0000, 32'h0000_0011, 2'b11);
        push_err();
        send(32'h0000_0004, 32'h0000_0022, 2'b10);
        idle();
        check("ready_aligned", {63'd0, req_ready}, 64'd1);

        // Misaligned word store
        send(32'h1000_0006, 32'hDDCC_BBAA, 2'b10);
        if (SPLIT_EN) begin
            push_beat(26'h000_0001, 32'hBBAA_0000, 8'b0000_1100);
            push_beat(26'h000_0002, 32'h0000_DDCC, 8'b0000_0011);
        end else begin
            push_err();
        end
        idle();
        check("ready_split", {63'd0, req_ready}, SPLIT_EN ? 64'd0 : 64'd1);
        idle();
        check("ready_after", {63'd0, req_ready}, 64'd1);

        // Split that wraps the word address back to zero within the tag
        send(32'h1FFF_FFFF, 32'h0000_1122, 2'b01);
        if (SPLIT_EN) begin
            push_beat(26'h3FF_FFFF, 32'h2200_0000, 8'b0000_1000);
            push_beat(26'h000_0000, 32'h0000_0011, 8'b0000_0001);
        end else begin
            push_err();
        end
        idle();
        idle();

        // Reset while the second beat is pending
        send(32'h1000_0006, 32'hDDCC_BBAA, 2'b10);
        if (SPLIT_EN) push_beat(26'h000_0001, 32'hBBAA_0000, 8'b0000_1100);
        else push_err();
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rsplit_valid", {63'd0, wr_valid}, 64'd0);
        check("rsplit_addr", {38'd0, wr_addr}, 64'd0);
        check("rsplit_data", {32'd0, wr_data}, 64'd0);
        check("rsplit_mask", {56'd0, wr_mask}, 64'd0);
        check("rsplit_err", {63'd0, err}, 64'd0);
        check("rsplit_ready", {63'd0, req_ready}, 64'd1);
        rst_n = 1'b1;
        repeat (3) idle();
        check("rsplit_no_beat1", {63'd0, wr_valid}, 64'd0);

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
